// File: rtl/shared_cnt_pkg.sv
// Shared definitions for the arbitrated shared-counter controller.
//   op_t    : per-requester operation code carried on the op bus
//   state_t : controller FSM states
//   CNT_W   : default counter width
package shared_cnt_pkg;

    localparam int unsigned CNT_W = 12;

    typedef enum logic [1:0] {
        OP_INC  = 2'b00,
        OP_DEC  = 2'b01,
        OP_LOAD = 2'b10,
        OP_READ = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_EXEC = 2'b01,
        S_RESP = 2'b10
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Searches upward from ptr+1, wrapping at NREQ, and returns the first active request.
// Ports:
//   req        in  NREQ  request levels
//   ptr        in  IDXW  index of the previous winner
//   winner     out NREQ  one-hot winner (all zero when no request)
//   winner_idx out IDXW  index of the winner (0 when no request)
module rr_arbiter #(
    parameter int unsigned  NREQ = 4,
    localparam int unsigned IDXW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDXW-1:0] ptr,
    output logic [NREQ-1:0] winner,
    output logic [IDXW-1:0] winner_idx
);

    // One extra bit so ptr+offset cannot overflow before the modulo fold.
    localparam int unsigned SW = IDXW + 1;

    logic [SW-1:0] cand;
    logic          found;

    always_comb begin
        winner     = '0;
        winner_idx = '0;
        found      = 1'b0;
        cand       = '0;
        for (int unsigned off = 1; off <= NREQ; off++) begin
            cand = {1'b0, ptr} + SW'(off);
            if (cand >= SW'(NREQ)) begin
                cand = cand - SW'(NREQ);
            end
            if (!found && req[cand[IDXW-1:0]]) begin
                found                      = 1'b1;
                winner[cand[IDXW-1:0]]     = 1'b1;
                winner_idx                 = cand[IDXW-1:0];
            end
        end
    end

endmodule

// File: rtl/shared_counter_ctrl.sv
// Shares one WIDTH-bit counter between NREQ requesters through a req/gnt handshake.
// A round-robin arbiter picks a requester in IDLE; EXEC applies the op; RESP strobes gnt.
// Build option: define SHARED_CNT_SAT_EN to saturate at the ends instead of wrapping
// (ovf/unf still flag the attempted crossing).
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   en         allow new grants (an in-flight op always completes)
//   req        per-requester request level
//   op         op for requester i at [2i+1:2i]
//   ld_data    LOAD value for requester i at [WIDTH*i +: WIDTH]
//   clr_flags  clear ovf/unf (a same-cycle set wins)
//   gnt        one-hot completion strobe, one cycle
//   rdata      counter value after the op, valid with gnt
//   cnt        live counter value
//   busy       FSM not in IDLE
//   ovf, unf   sticky increment/decrement crossing flags
module shared_counter_ctrl
    import shared_cnt_pkg::*;
#(
    parameter int unsigned WIDTH = CNT_W,
    parameter int unsigned NREQ  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [NREQ-1:0]       req,
    input  logic [2*NREQ-1:0]     op,
    input  logic [WIDTH*NREQ-1:0] ld_data,
    input  logic                  clr_flags,
    output logic [NREQ-1:0]       gnt,
    output logic [WIDTH-1:0]      rdata,
    output logic [WIDTH-1:0]      cnt,
    output logic                  busy,
    output logic                  ovf,
    output logic                  unf
);

    localparam int unsigned    IDXW    = $clog2(NREQ);
    localparam logic [WIDTH-1:0] CNT_MAX = '1;

    state_t           state_q, state_d;
    logic [IDXW-1:0]  ptr_q, ptr_d;
    op_t              op_q, op_d;
    logic [WIDTH-1:0] ld_q, ld_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    logic [NREQ-1:0]  win_oh;
    logic [IDXW-1:0]  win_idx;
    logic [1:0]       op_sel;
    logic [WIDTH-1:0] ld_sel;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .req        (req),
        .ptr        (ptr_q),
        .winner     (win_oh),
        .winner_idx (win_idx)
    );

    // Select the winner's op and load value from the flat buses.
    always_comb begin
        op_sel = '0;
        ld_sel = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (win_oh[i]) begin
                op_sel = op[2*i +: 2];
                ld_sel = ld_data[WIDTH*i +: WIDTH];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        op_d    = op_q;
        ld_d    = ld_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        // Clear first; a set in EXEC below overrides it.
        ovf_d   = ovf_q & ~clr_flags;
        unf_d   = unf_q & ~clr_flags;
        gnt     = '0;

        unique case (state_q)
            S_IDLE: begin
                if (en && |req) begin
                    op_d    = op_t'(op_sel);
                    ld_d    = ld_sel;
                    ptr_d   = win_idx;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                unique case (op_q)
                    OP_INC: begin
                        if (cnt_q == CNT_MAX) begin
                            ovf_d = 1'b1;
`ifdef SHARED_CNT_SAT_EN
                            cnt_d = CNT_MAX;
`else
                            cnt_d = '0;
`endif
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                    OP_DEC: begin
                        if (cnt_q == '0) begin
                            unf_d = 1'b1;
`ifdef SHARED_CNT_SAT_EN
                            cnt_d = '0;
`else
                            cnt_d = CNT_MAX;
`endif
                        end else begin
                            cnt_d = cnt_q - 1'b1;
                        end
                    end
                    OP_LOAD: cnt_d = ld_q;
                    OP_READ: cnt_d = cnt_q;
                    default: cnt_d = cnt_q;
                endcase
                rdata_d = cnt_d;
                state_d = S_RESP;
            end
            S_RESP: begin
                gnt[ptr_q] = 1'b1;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            // Start at the last index so requester 0 wins first.
            ptr_q   <= IDXW'(NREQ - 1);
            op_q    <= OP_INC;
            ld_q    <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            op_q    <= op_d;
            ld_q    <= ld_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign rdata = rdata_q;
    assign cnt   = cnt_q;
    assign busy  = (state_q != S_IDLE);
    assign ovf   = ovf_q;
    assign unf   = unf_q;

endmodule
